div_seq_param: RTL and testbench

//  - Parametrised, multi-cycle radix-2 restoring divider. Successor to the 16b/8b combinational divider.
//  - One quotient bit per clock. Valid/ready handshake on input and output. Divide-by-zero flag.
//  - Sits between operand producers and consumers that can absorb DIVIDEND_W-cycle latency.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 29 ++
 rtl/div_seq_param.sv | 194 +++++++++++++++++++
 tb/tb_div_seq_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e    : controller states
//   clog2()    : bits needed to count 0..v-1 (used with DIVIDEND_W+1)
//   DIV_ZERO_Q : fill bit for the divide-by-zero quotient (all ones)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIV_ZERO_Q = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step.
//   partial_i : running remainder (always < divisor)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : divisor magnitude
//   partial_o : updated remainder
//   q_o       : quotient bit produced by this step
module div_step #(
  parameter int unsigned DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] partial_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] partial_o,
  output logic                 q_o
);

  logic [DIVISOR_W:0]   trial;
  logic [DIVISOR_W-1:0] diff;

  always_comb begin
    trial = {partial_i, bit_i};
    q_o   = (trial >= {1'b0, divisor_i});
    // A successful subtraction always leaves a value below the divisor,
    // so the low DIVISOR_W bits of the difference are exact.
    diff      = trial[DIVISOR_W-1:0] - divisor_i;
    partial_o = q_o ? diff : trial[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Optional signed mode is enabled by defining DIV_SIGNED_EN, which adds
// the signed_i port.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only when idle)
//   dividend, divisor   : A (DIVIDEND_W bits), B (DIVISOR_W bits)
//   signed_i            : two's complement operation (DIV_SIGNED_EN only)
//   out_valid/out_ready : result handshake, result held until consumed
//   quotient, remainder : A / B, A % B
//   div_by_zero         : B was zero for this result
module div_seq_param
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
`ifdef DIV_SIGNED_EN
  input  logic                  signed_i,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  if (DIVIDEND_W < 2 || DIVISOR_W < 2 || DIVISOR_W > DIVIDEND_W) begin : g_bad_params
    $error("div_seq_param: need DIVIDEND_W >= 2 and 2 <= DIVISOR_W <= DIVIDEND_W");
  end

  localparam int unsigned CNT_W = clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] a_q, a_d;
  logic [DIVISOR_W-1:0]  b_q, b_d;
  logic [DIVISOR_W-1:0]  p_q, p_d;
  logic                  zero_q, zero_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic                  a_neg, b_neg;
`endif

  logic [DIVIDEND_W-1:0] a_mag;
  logic [DIVISOR_W-1:0]  b_mag;
  logic [DIVISOR_W-1:0]  step_p;
  logic                  step_q;
  logic [DIVIDEND_W-1:0] quo_raw, quo_fin;
  logic [DIVISOR_W-1:0]  rem_raw, rem_fin;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .partial_i (p_q),
    .bit_i     (a_q[DIVIDEND_W-1]),
    .divisor_i (b_q),
    .partial_o (step_p),
    .q_o       (step_q)
  );

  // Operand conditioning on accept: the datapath only ever sees magnitudes.
  always_comb begin
`ifdef DIV_SIGNED_EN
    a_neg = signed_i & dividend[DIVIDEND_W-1];
    b_neg = signed_i & divisor[DIVISOR_W-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
`else
    a_mag = dividend;
    b_mag = divisor;
`endif
  end

  // Result of the final iteration, with signs re-applied when enabled.
  always_comb begin
    quo_raw = {a_q[DIVIDEND_W-2:0], step_q};
    rem_raw = step_p;
`ifdef DIV_SIGNED_EN
    quo_fin = qneg_q ? -quo_raw : quo_raw;
    rem_fin = rneg_q ? -rem_raw : rem_raw;
`else
    quo_fin = quo_raw;
    rem_fin = rem_raw;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          zero_d  = (divisor == '0);
          // Divide-by-zero keeps the raw dividend for the remainder output.
          a_d     = (divisor == '0) ? dividend : a_mag;
          b_d     = b_mag;
          p_d     = '0;
          cnt_d   = '0;
`ifdef DIV_SIGNED_EN
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        if (zero_q) begin
          // Divide-by-zero spends a single CALC cycle, so its result
          // appears one edge after the accept edge.
          quo_d   = {DIVIDEND_W{DIV_ZERO_Q}};
          rem_d   = a_q[DIVISOR_W-1:0];
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          // a_q shifts left: its MSB feeds the step, quotient bits enter at the LSB.
          a_d   = quo_raw;
          p_d   = step_p;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            quo_d   = quo_fin;
            rem_d   = rem_fin;
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Directed bench for div_seq_param: a default 16/8 instance and a 32/16 instance.
module tb_div_seq_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        n_in_valid = 1'b0, n_out_ready = 1'b0;
  logic [15:0] n_dividend = '0;
  logic [7:0]  n_divisor = '0;
  logic        n_in_ready, n_out_valid, n_dbz;
  logic [15:0] n_quotient;
  logic [7:0]  n_remainder;

  logic        w_in_valid = 1'b0, w_out_ready = 1'b0;
  logic [31:0] w_dividend = '0;
  logic [15:0] w_divisor = '0;
  logic        w_in_ready, w_out_valid, w_dbz;
  logic [31:0] w_quotient;
  logic [15:0] w_remainder;

`ifdef DIV_SIGNED_EN
  logic n_signed = 1'b0, w_signed = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_seq_param u_narrow (
    .clk (clk), .rst (rst),
    .in_valid (n_in_valid), .in_ready (n_in_ready),
    .dividend (n_dividend), .divisor (n_divisor),
`ifdef DIV_SIGNED_EN
    .signed_i (n_signed),
`endif
    .out_valid (n_out_valid), .out_ready (n_out_ready),
    .quotient (n_quotient), .remainder (n_remainder), .div_by_zero (n_dbz)
  );

  div_seq_param #(
    .DIVIDEND_W (32),
    .DIVISOR_W  (16)
  ) u_wide (
    .clk (clk), .rst (rst),
    .in_valid (w_in_valid), .in_ready (w_in_ready),
    .dividend (w_dividend), .divisor (w_divisor),
`ifdef DIV_SIGNED_EN
    .signed_i (w_signed),
`endif
    .out_valid (w_out_valid), .out_ready (w_out_ready),
    .quotient (w_quotient), .remainder (w_remainder), .div_by_zero (w_dbz)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wide, input logic [31:0] a, input logic [15:0] b, input logic s);
    int n;
    n = 0;
    while (((wide ? w_in_ready : n_in_ready) !== 1'b1) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'(0), 64'(1));
`ifdef DIV_SIGNED_EN
    if (wide) w_signed = s; else n_signed = s;
`else
    if (s) $fatal(1, "signed operation requested without DIV_SIGNED_EN");
`endif
    if (wide) begin
      w_dividend = a; w_divisor = b; w_in_valid = 1'b1;
    end else begin
      n_dividend = a[15:0]; n_divisor = b[7:0]; n_in_valid = 1'b1;
    end
    tick();
    // Scramble operands after the accept edge; the registered copy must be used.
    w_in_valid = 1'b0; n_in_valid = 1'b0;
    w_dividend = $urandom; w_divisor = 16'($urandom);
    n_dividend = 16'($urandom); n_divisor = 8'($urandom);
  endtask

  task automatic wait_done(input bit wide, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (((wide ? w_out_valid : n_out_valid) !== 1'b1) && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_res(input bit wide, input logic [31:0] q, input logic [15:0] r,
                           input logic dbz, input string tag);
    if (wide) begin
      check({tag, "_q"}, 64'(w_quotient), 64'(q));
      check({tag, "_r"}, 64'(w_remainder), 64'(r));
      check({tag, "_dbz"}, 64'(w_dbz), 64'(dbz));
      check({tag, "_rdy"}, 64'(w_in_ready), 64'(0));
    end else begin
      check({tag, "_q"}, 64'(n_quotient), 64'(q));
      check({tag, "_r"}, 64'(n_remainder), 64'(r));
      check({tag, "_dbz"}, 64'(n_dbz), 64'(dbz));
      check({tag, "_rdy"}, 64'(n_in_ready), 64'(0));
    end
  endtask

  task automatic consume(input bit wide, input logic [31:0] q, input string tag);
    if (wide) w_out_ready = 1'b1; else n_out_ready = 1'b1;
    tick();
    w_out_ready = 1'b0; n_out_ready = 1'b0;
    check({tag, "_idle_ov"}, 64'(wide ? w_out_valid : n_out_valid), 64'(0));
    check({tag, "_idle_rdy"}, 64'(wide ? w_in_ready : n_in_ready), 64'(1));
    check({tag, "_hold_q"}, 64'(wide ? w_quotient : {16'd0, n_quotient}), 64'(q));
  endtask

  task automatic op(input bit wide, input logic [31:0] a, input logic [15:0] b, input logic s,
                    input logic [31:0] q, input logic [15:0] r, input logic dbz,
                    input int lat, input string tag);
    issue(wide, a, b, s);
    wait_done(wide, lat, tag);
    check_res(wide, q, r, dbz, tag);
    consume(wide, q, tag);
  endtask

  logic [15:0] va [5];
  logic [7:0]  vb [5];
  logic [31:0] ra;
  logic [15:0] rb;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_n_rdy", 64'(n_in_ready), 64'(1));
    check("rst_n_ov", 64'(n_out_valid), 64'(0));
    check("rst_n_q", 64'(n_quotient), 64'(0));
    check("rst_n_r", 64'(n_remainder), 64'(0));
    check("rst_n_dbz", 64'(n_dbz), 64'(0));
    check("rst_w_rdy", 64'(w_in_ready), 64'(1));
    check("rst_w_ov", 64'(w_out_valid), 64'(0));
    check("rst_w_q", 64'(w_quotient), 64'(0));
    rst = 1'b0;
    tick();

    // Basic unsigned divisions with hand-computed results
    op(1'b0, 32'd1000, 16'd7, 1'b0, 32'd142, 16'd6, 1'b0, 16, "t1000_7");
    op(1'b0, 32'hFFFF, 16'hFF, 1'b0, 32'h0101, 16'h00, 1'b0, 16, "tffff_ff");
    op(1'b0, 32'h0005, 16'h09, 1'b0, 32'h0000, 16'h05, 1'b0, 16, "t5_9");

    // Divide by zero: one-edge latency, all-ones quotient, raw low dividend bits
    op(1'b0, 32'h1234, 16'h00, 1'b0, 32'hFFFF, 16'h34, 1'b1, 1, "tdbz");

    // Boundary operands against the arithmetic model
    va[0] = 16'hFFFF; vb[0] = 8'h01;
    va[1] = 16'h0000; vb[1] = 8'h05;
    va[2] = 16'h8001; vb[2] = 8'hFE;
    va[3] = 16'hABCD; vb[3] = 8'h80;
    va[4] = 16'hFF9C; vb[4] = 8'h07;
    for (int unsigned i = 0; i < 5; i++) begin
      op(1'b0, 32'(va[i]), 16'(vb[i]), 1'b0, 32'(va[i] / 16'(vb[i])),
         16'(va[i] % 16'(vb[i])), 1'b0, 16, $sformatf("model%0d", i));
    end

    // Hold in DONE with out_ready low while new operands are offered
    issue(1'b0, 32'd1000, 16'd7, 1'b0);
    wait_done(1'b0, 16, "hold");
    n_dividend = 16'd5; n_divisor = 8'd1; n_in_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d_ov", i), 64'(n_out_valid), 64'(1));
      check($sformatf("hold%0d_rdy", i), 64'(n_in_ready), 64'(0));
      check($sformatf("hold%0d_q", i), 64'(n_quotient), 64'(142));
      check($sformatf("hold%0d_r", i), 64'(n_remainder), 64'(6));
    end
    n_in_valid = 1'b0;
    consume(1'b0, 32'd142, "hold_rel");

    // Reset in the middle of 100/3 (after iteration 8), then a clean run
    issue(1'b0, 32'd100, 16'd3, 1'b0);
    repeat (8) tick();
    check("mid_busy", 64'(n_in_ready), 64'(0));
    rst = 1'b1;
    #1;
    check("mid_rst_ov", 64'(n_out_valid), 64'(0));
    check("mid_rst_q", 64'(n_quotient), 64'(0));
    check("mid_rst_r", 64'(n_remainder), 64'(0));
    check("mid_rst_rdy", 64'(n_in_ready), 64'(1));
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ov", 64'(n_out_valid), 64'(0));
    op(1'b0, 32'd100, 16'd3, 1'b0, 32'd33, 16'd1, 1'b0, 16, "t100_3");

`ifdef DIV_SIGNED_EN
    op(1'b0, 32'hFF9C, 16'h07, 1'b1, 32'hFFF2, 16'hFE, 1'b0, 16, "s_m100_7");
    op(1'b0, 32'h0064, 16'hF9, 1'b1, 32'hFFF2, 16'h02, 1'b0, 16, "s_100_m7");
    op(1'b0, 32'hFF9C, 16'hF9, 1'b1, 32'h000E, 16'hFE, 1'b0, 16, "s_m100_m7");
    op(1'b0, 32'h8000, 16'hFF, 1'b1, 32'h8000, 16'h00, 1'b0, 16, "s_min_m1");
    op(1'b0, 32'hFF9C, 16'h00, 1'b1, 32'hFFFF, 16'h9C, 1'b1, 1, "s_dbz");
    op(1'b0, 32'hFF9C, 16'h07, 1'b0, 32'(16'hFF9C / 16'h0007),
       16'(16'hFF9C % 16'h0007), 1'b0, 16, "s_off");
`endif

    // Wide configuration: boundaries, divide by zero, random operands
    op(1'b1, 32'hFFFF_FFFF, 16'h0001, 1'b0, 32'hFFFF_FFFF, 16'h0000, 1'b0, 32, "w_max_1");
    op(1'b1, 32'hDEAD_BEEF, 16'h0000, 1'b0, 32'hFFFF_FFFF, 16'hBEEF, 1'b1, 1, "w_dbz");
    for (int unsigned i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = 16'($urandom_range(1, 65535));
      op(1'b1, ra, rb, 1'b0, ra / 32'(rb), 16'(ra % 32'(rb)), 1'b0, 32,
         $sformatf("w_rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
